// File: rtl/int_alu_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// int_alu_unit : bus-mapped 16-bit ALU, single-cycle logic + iterative MUL/DIV
// Revision     : 1.0
// ============================================================================
module int_alu_unit #(
  parameter logic [3:0] MOD_ID = 4'h3,
  parameter int         DATA_W = 16,
  parameter int         OUT_W  = 256
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic [15:0]       address,
  input  logic              nRead,
  input  logic              nWrite,
  input  logic [OUT_W-1:0]  ExeDataOut,
  output logic [OUT_W-1:0]  IntDataOut
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [11:0] c_OFF_SRC1 = 12'd0;
  localparam logic [11:0] c_OFF_SRC2 = 12'd1;
  localparam logic [11:0] c_OFF_RES  = 12'd2;
  localparam logic [11:0] c_OFF_OPC  = 12'd3;
  localparam logic [11:0] c_OFF_STAT = 12'd4;

  localparam logic [7:0] c_OP_ADD = 8'h10;
  localparam logic [7:0] c_OP_SUB = 8'h11;
  localparam logic [7:0] c_OP_MUL = 8'h12;
  localparam logic [7:0] c_OP_DIV = 8'h13;
  localparam logic [7:0] c_OP_AND = 8'h14;
  localparam logic [7:0] c_OP_OR  = 8'h15;
  localparam logic [7:0] c_OP_XOR = 8'h16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC1  = 2'd1,
    MULDIV = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   src1_q, src1_d, src2_q, src2_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [7:0]          opc_q, opc_d;
  logic [RES_W-1:0]    res_q, res_d, work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                divz_q, divz_d, ill_q, ill_d, ovr_q, ovr_d;
  logic [OUT_W-1:0]    dout_q, dout_d;

  logic                w_sel, w_wr, w_rd, w_start, w_drop, w_iter;
  logic [11:0]         w_off;
  logic [7:0]          w_new_opc;
  logic [OUT_W-1:0]    w_rdata;
  logic [DATA_W:0]     w_add_sum, w_mul_sum, w_div_rem, w_div_trial;
  logic [DATA_W-1:0]   w_sub_diff;
  logic [RES_W-1:0]    w_alu, w_mul_next, w_div_next, w_step;
  logic                w_legal;
  logic                w_unused;

  assign w_unused = ^ExeDataOut[OUT_W-1:DATA_W];

  assign w_sel     = (address[15:12] == MOD_ID);
  assign w_off     = address[11:0];
  assign w_wr      = w_sel && !nWrite;
  assign w_rd      = w_sel && !nRead && nWrite;
  assign w_start   = w_wr && (w_off == c_OFF_OPC) && !busy_q;
  assign w_drop    = w_wr && (w_off == c_OFF_OPC) && busy_q;
  assign w_new_opc = ExeDataOut[7:0];

  // Shift-add multiply: low half holds the remaining multiplier bits.
  assign w_mul_sum  = {1'b0, work_q[RES_W-1:DATA_W]} +
                      (work_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, work_q[DATA_W-1:1]};

  // Restoring divide: high half is the partial remainder, low half the quotient.
  assign w_div_rem   = work_q[RES_W-1:DATA_W-1];
  assign w_div_trial = w_div_rem - {1'b0, opb_q};
  assign w_div_next  = w_div_trial[DATA_W]
                     ? {w_div_rem[DATA_W-1:0], work_q[DATA_W-2:0], 1'b0}
                     : {w_div_trial[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};

  assign w_step     = (opc_q == c_OP_MUL) ? w_mul_next : w_div_next;
  assign w_add_sum  = {1'b0, opa_q} + {1'b0, opb_q};
  assign w_sub_diff = opa_q - opb_q;

  always_comb begin
    w_alu   = '0;
    w_legal = 1'b1;
    case (opc_q)
      c_OP_ADD: w_alu = {{(RES_W-DATA_W-1){1'b0}}, w_add_sum};
      c_OP_SUB: w_alu = {{DATA_W{w_sub_diff[DATA_W-1]}}, w_sub_diff};
      c_OP_AND: w_alu = {{DATA_W{1'b0}}, opa_q & opb_q};
      c_OP_OR:  w_alu = {{DATA_W{1'b0}}, opa_q | opb_q};
      c_OP_XOR: w_alu = {{DATA_W{1'b0}}, opa_q ^ opb_q};
      c_OP_DIV: w_alu = {{DATA_W{1'b0}}, {DATA_W{1'b1}}};
      default:  w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_OFF_RES, c_OFF_OPC: w_rdata[RES_W-1:0] = res_q;
      c_OFF_STAT:           w_rdata[4:0] = {ovr_q, ill_q, divz_q, done_q, busy_q};
      default:              w_rdata = '0;
    endcase
  end

  assign w_iter = (w_new_opc == c_OP_MUL) ||
                  ((w_new_opc == c_OP_DIV) && (src2_q != '0));

  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opc_d   = opc_q;
    res_d   = res_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    divz_d  = divz_q;
    ill_d   = ill_q;
    ovr_d   = ovr_q;
    dout_d  = dout_q;

    if (w_wr && (w_off == c_OFF_SRC1)) src1_d = ExeDataOut[DATA_W-1:0];
    if (w_wr && (w_off == c_OFF_SRC2)) src2_d = ExeDataOut[DATA_W-1:0];
    if (w_drop) ovr_d = 1'b1;
    if (w_rd)   dout_d = w_rdata;

    case (state_q)
      IDLE, DONE: begin
        if (w_start) begin
          opa_d  = src1_q;
          opb_d  = src2_q;
          opc_d  = w_new_opc;
          busy_d = 1'b1;
          done_d = 1'b0;
          divz_d = 1'b0;
          ill_d  = 1'b0;
          ovr_d  = 1'b0;
          if (w_iter) begin
            state_d = MULDIV;
            cnt_d   = '0;
            work_d  = {{DATA_W{1'b0}}, src1_q};
          end else begin
            state_d = EXEC1;
          end
        end
      end
      EXEC1: begin
        res_d   = w_alu;
        ill_d   = !w_legal;
        divz_d  = (opc_q == c_OP_DIV);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      MULDIV: begin
        work_d = w_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          res_d   = w_step;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q <= IDLE;
      src1_q  <= '0;
      src2_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      res_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      ill_q   <= 1'b0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      res_q   <= res_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
      ill_q   <= ill_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
    end
  end

  assign IntDataOut = dout_q;

endmodule
`default_nettype wire
